// File: rtl/mem_master.sv
// ============================================================================
// Module   : mem_master
// Purpose  : Sequencing memory master. Walks an address range issuing
//            valid/ready write and/or read requests with a seed+address data
//            pattern. Read data is captured one cycle after each read
//            handshake.
// Option   : MEM_MASTER_CHECK_EN - when defined, each captured read is
//            compared against seed+address. err_cnt counts mismatches and
//            saturates. first_err_addr records the first failing address.
//            When undefined, both outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_master #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH:0]   start_addr,
  input  logic [ADDR_WIDTH:0]   end_addr,
  input  logic [WIDTH-1:0]      seed,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic                  ready,
  input  logic [WIDTH-1:0]      rdata,
  output logic [WIDTH-1:0]      rd_data_out,
  output logic                  rd_data_vld,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  // Upper bound for the exclusive end address.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

  // LOAD gives one cycle to resolve the latched range before issuing.
  // GAP is the idle cycle between the write and read phases.
  // RWAIT waits for the last read data to arrive.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    GAP   = 3'd3,
    READ  = 3'd4,
    RWAIT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                state;
  logic [1:0]            mode_l;
  logic [ADDR_WIDTH:0]   lo_l;
  logic [ADDR_WIDTH:0]   hi_l;
  logic [WIDTH-1:0]      seed_l;
  logic [ADDR_WIDTH:0]   cur;
  logic                  rd_pend;
  logic [ADDR_WIDTH-1:0] pend_addr;

  logic [ADDR_WIDTH:0]   next_cur;
  logic                  last_xfer;
  logic [WIDTH-1:0]      next_wdata;
  logic [WIDTH-1:0]      first_wdata;

  assign next_cur    = cur + 1'b1;
  assign last_xfer   = (next_cur == hi_l);
  assign next_wdata  = seed_l + WIDTH'(next_cur);
  assign first_wdata = seed_l + WIDTH'(lo_l);

  // Sequencer: state, latched command and all request outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode_l    <= 2'b00;
      lo_l      <= '0;
      hi_l      <= '0;
      seed_l    <= '0;
      cur       <= '0;
      valid     <= 1'b0;
      wr_rd     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_pend   <= 1'b0;
      pend_addr <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Reserved mode 11 behaves as write-only.
            mode_l <= (mode == 2'b11) ? 2'b00 : mode;
            lo_l   <= start_addr;
            hi_l   <= (end_addr > DEPTH_LIM) ? DEPTH_LIM : end_addr;
            seed_l <= seed;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (hi_l <= lo_l) begin
            // Empty range: finish without any request.
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cur   <= lo_l;
            valid <= 1'b1;
            addr  <= lo_l[ADDR_WIDTH-1:0];
            if (mode_l == 2'b01) begin
              wr_rd <= 1'b0;
              state <= READ;
            end else begin
              wr_rd <= 1'b1;
              wdata <= first_wdata;
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (ready) begin
            if (last_xfer) begin
              valid <= 1'b0;
              if (mode_l == 2'b10) begin
                state <= GAP;
              end else begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              cur   <= next_cur;
              addr  <= next_cur[ADDR_WIDTH-1:0];
              wdata <= next_wdata;
            end
          end
        end
        GAP: begin
          cur   <= lo_l;
          valid <= 1'b1;
          wr_rd <= 1'b0;
          addr  <= lo_l[ADDR_WIDTH-1:0];
          state <= READ;
        end
        READ: begin
          if (ready) begin
            rd_pend   <= 1'b1;
            pend_addr <= addr;
            if (last_xfer) begin
              valid <= 1'b0;
              state <= RWAIT;
            end else begin
              cur  <= next_cur;
              addr <= next_cur[ADDR_WIDTH-1:0];
            end
          end
        end
        RWAIT: begin
          // Final read data is captured on this edge.
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Capture read data one cycle after each read handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_out <= '0;
      rd_data_vld <= 1'b0;
    end else begin
      rd_data_vld <= rd_pend;
      if (rd_pend) begin
        rd_data_out <= rdata;
      end
    end
  end

`ifdef MEM_MASTER_CHECK_EN
  logic [WIDTH-1:0] exp_rdata;
  assign exp_rdata = seed_l + WIDTH'(pend_addr);

  // Compare captured reads against the pattern; count saturates at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (state == IDLE && start) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (rd_pend && (rdata != exp_rdata)) begin
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (err_cnt == '0) begin
        first_err_addr <= pend_addr;
      end
    end
  end
`else
  assign err_cnt        = '0;
  assign first_err_addr = '0;
  logic unused_pend;
  assign unused_pend = ^pend_addr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_master.sv
// ============================================================================
// Module   : tb_mem_master
// Purpose  : Self-checking bench for mem_master with a latency-1 memory model
//            and an expected-request / expected-read-data scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_master;

  localparam int DEPTH = 16;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [15:0]   d;
  } req_t;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1:0]      mode;
  logic [AW:0]     start_addr;
  logic [AW:0]     end_addr;
  logic [15:0]     seed;
  logic            valid;
  logic            wr_rd;
  logic [AW-1:0]   addr;
  logic [15:0]     wdata;
  logic            ready;
  logic [15:0]     rdata;
  logic [15:0]     rd_data_out;
  logic            rd_data_vld;
  logic            busy;
  logic            done;
  logic [AW:0]     err_cnt;
  logic [AW-1:0]   first_err_addr;

  int checks   = 0;
  int failures = 0;

  req_t        exp_req[$];
  logic [15:0] exp_rd[$];
  logic [15:0] shadow[0:DEPTH-1];
  logic [15:0] mem[0:DEPTH-1];
  int          corrupt_addr = -1;

  mem_master #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .start_addr(start_addr), .end_addr(end_addr), .seed(seed),
    .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rd_data_out(rd_data_out),
    .rd_data_vld(rd_data_vld), .busy(busy), .done(done),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes store (optionally corrupted), reads return next cycle.
  always @(posedge clk) begin
    if (valid && ready) begin
      if (wr_rd) mem[addr] <= (int'(addr) == corrupt_addr) ? (wdata ^ 16'h0001) : wdata;
      else       rdata     <= mem[addr];
    end
  end

  task automatic run_seq(input string name, input logic [1:0] m, input int s, input int e,
                         input logic [15:0] sd, input int stall_addr, input int stall_n,
                         input bit spurious);
    int hi, n, exp_done, cyc, done_cnt, done_cyc, left, exp_err, exp_first, valid_cycles;
    logic [1:0] eff;
    req_t r;
    logic [15:0] er, pat;
    eff = (m == 2'b11) ? 2'b00 : m;
    hi  = (e > DEPTH) ? DEPTH : e;
    n   = (hi > s) ? hi - s : 0;
    exp_err = 0; exp_first = 0;
    exp_req.delete(); exp_rd.delete();
    if (n > 0 && eff != 2'b01) begin
      for (int a = s; a < hi; a++) begin
        pat = 16'(sd + a);
        r.wr = 1'b1; r.a = AW'(a); r.d = pat;
        exp_req.push_back(r);
        shadow[a] = (a == corrupt_addr) ? (pat ^ 16'h0001) : pat;
      end
    end
    if (n > 0 && eff != 2'b00) begin
      for (int a = s; a < hi; a++) begin
        pat = 16'(sd + a);
        r.wr = 1'b0; r.a = AW'(a); r.d = 16'h0;
        exp_req.push_back(r);
        exp_rd.push_back(shadow[a]);
        if (shadow[a] != pat) begin
          if (exp_err == 0) exp_first = a;
          if (exp_err < 31) exp_err++;
        end
      end
    end
`ifndef MEM_MASTER_CHECK_EN
    exp_err = 0; exp_first = 0;
`endif
    if (n == 0)              exp_done = 2;
    else if (eff == 2'b00)   exp_done = n + 2 + stall_n;
    else if (eff == 2'b01)   exp_done = n + 3 + stall_n;
    else                     exp_done = 2 * n + 4 + stall_n;

    @(posedge clk); #1;
    mode = m; start_addr = (AW+1)'(s); end_addr = (AW+1)'(e); seed = sd; start = 1'b1;

    cyc = 0; done_cnt = 0; done_cyc = -100; left = stall_n; valid_cycles = 0;
    while (cyc < 300 && !(done_cnt > 0 && cyc >= done_cyc + 3)) begin
      @(posedge clk); #1;
      start = spurious && (cyc == 2);
      if (start) begin
        mode = 2'b01; start_addr = '0; end_addr = 5'd16; seed = 16'hFFFF;
      end
      if (valid && wr_rd && int'(addr) == stall_addr && left > 0) begin
        ready = 1'b0; left--;
      end else begin
        ready = 1'b1;
      end
      @(negedge clk); cyc++;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++; $display("FAIL %s.busy_after_start: got %b want 1", name, busy);
        end
      end
      if (!ready) begin
        checks++;
        if (int'(addr) != stall_addr || wdata !== 16'(sd + stall_addr) || valid !== 1'b1) begin
          failures++;
          $display("FAIL %s.stall_hold: got valid=%b addr=%0d wdata=%h want valid=1 addr=%0d wdata=%h",
                   name, valid, addr, wdata, stall_addr, 16'(sd + stall_addr));
        end
      end
      if (valid) valid_cycles++;
      if (valid && ready) begin
        checks++;
        if (exp_req.size() == 0) begin
          failures++;
          $display("FAIL %s.extra_request: got wr=%b addr=%0d want no request", name, wr_rd, addr);
        end else begin
          r = exp_req.pop_front();
          if (wr_rd !== r.wr || addr !== r.a || (r.wr && wdata !== r.d)) begin
            failures++;
            $display("FAIL %s.request: got wr=%b addr=%0d wdata=%h want wr=%b addr=%0d wdata=%h",
                     name, wr_rd, addr, wdata, r.wr, r.a, r.d);
          end
        end
      end
      if (rd_data_vld) begin
        checks++;
        if (exp_rd.size() == 0) begin
          failures++;
          $display("FAIL %s.extra_rd_data: got %h want none", name, rd_data_out);
        end else begin
          er = exp_rd.pop_front();
          if (rd_data_out !== er) begin
            failures++;
            $display("FAIL %s.rd_data: got %h want %h", name, rd_data_out, er);
          end
        end
      end
      if (done) begin
        done_cnt++; done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin
          failures++; $display("FAIL %s.busy_in_done: got %b want 0", name, busy);
        end
      end
    end
    ready = 1'b1;

    checks++;
    if (done_cnt != 1) begin
      failures++; $display("FAIL %s.done_count: got %0d want 1", name, done_cnt);
    end
    checks++;
    if (done_cyc != exp_done) begin
      failures++; $display("FAIL %s.done_cycle: got %0d want %0d", name, done_cyc, exp_done);
    end
    checks++;
    if (exp_req.size() != 0 || exp_rd.size() != 0) begin
      failures++;
      $display("FAIL %s.missing_transfers: got %0d req %0d rd left want 0 0", name, exp_req.size(), exp_rd.size());
    end
    checks++;
    if (err_cnt !== (AW+1)'(exp_err) || first_err_addr !== AW'(exp_first)) begin
      failures++;
      $display("FAIL %s.errors: got err_cnt=%0d first=%0d want err_cnt=%0d first=%0d",
               name, err_cnt, first_err_addr, exp_err, exp_first);
    end
    if (n == 0) begin
      checks++;
      if (valid_cycles != 0) begin
        failures++; $display("FAIL %s.empty_valid: got %0d valid cycles want 0", name, valid_cycles);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || wr_rd !== 1'b0 || addr !== '0 || wdata !== '0) begin
      failures++; $display("FAIL reset.request: got valid=%b wr=%b addr=%0d wdata=%h want 0 0 0 0", valid, wr_rd, addr, wdata);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_data_vld !== 1'b0 || rd_data_out !== '0) begin
      failures++; $display("FAIL reset.status: got busy=%b done=%b vld=%b rd=%h want 0 0 0 0", busy, done, rd_data_vld, rd_data_out);
    end
    checks++;
    if (err_cnt !== '0 || first_err_addr !== '0) begin
      failures++; $display("FAIL reset.errors: got %0d %0d want 0 0", err_cnt, first_err_addr);
    end
    rst = 1'b1;
  endtask

  task automatic test_write_only();
    run_seq("write_only", 2'b00, 0, 5, 16'h0100, -1, 0, 1'b0);
  endtask

  task automatic test_write_read();
    run_seq("write_read_full", 2'b10, 0, 16, 16'hA5A5, -1, 0, 1'b0);
  endtask

  task automatic test_read_only();
    run_seq("read_only", 2'b01, 0, 4, 16'hA5A5, -1, 0, 1'b0);
  endtask

  task automatic test_mismatch();
    corrupt_addr = 6;
    run_seq("mismatch", 2'b10, 4, 8, 16'h1234, -1, 0, 1'b0);
    corrupt_addr = -1;
  endtask

  task automatic test_stall();
    run_seq("stall", 2'b00, 0, 5, 16'h0200, 2, 3, 1'b0);
  endtask

  task automatic test_empty_and_clamp();
    run_seq("empty", 2'b00, 8, 8, 16'h0300, -1, 0, 1'b0);
    run_seq("clamp", 2'b00, 12, 20, 16'h0400, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq("reserved_busy_start", 2'b11, 0, 5, 16'h0777, -1, 0, 1'b1);
    run_seq("back_to_back_rd", 2'b01, 0, 5, 16'h0777, -1, 0, 1'b0);
  endtask

  task automatic test_mid_reset();
    bit hit, bad;
    hit = 1'b0; bad = 1'b0;
    @(posedge clk); #1;
    mode = 2'b10; start_addr = 5'd0; end_addr = 5'd16; seed = 16'h0F0F; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (valid && wr_rd && addr == 4'd3) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL mid_reset.reach_addr3: got no write of addr 3 want one");
    end
    rst = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr !== '0 || wdata !== '0 || wr_rd !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset.immediate: got valid=%b busy=%b done=%b addr=%0d wdata=%h wr=%b want all 0",
               valid, busy, done, addr, wdata, wr_rd);
    end
    repeat (4) begin
      @(negedge clk);
      if (valid || busy || done) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL mid_reset.quiet: got activity during reset want none");
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (valid || busy || done) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL mid_reset.no_resume: got activity after release want none");
    end
    run_seq("after_reset", 2'b00, 0, 4, 16'h0042, -1, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 2'b00; start_addr = '0; end_addr = '0;
    seed = '0; ready = 1'b1;
    test_reset();
    test_write_only();
    test_write_read();
    test_read_only();
    test_mismatch();
    test_stall();
    test_empty_and_clamp();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
